// File: rtl/uart_seq_pkg.sv
// Shared types and default constants for the UART multiply command sequencer.
// PROD_W is the product width for the default operand width.
package uart_seq_pkg;

  localparam int BYTE_W     = 8;
  localparam int DEF_DATA_W = 8;
  localparam int PROD_W     = 2 * DEF_DATA_W;

  localparam logic [BYTE_W-1:0] DEF_OPC_MUL  = 8'h4D;
  localparam logic [BYTE_W-1:0] DEF_ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    MUL,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    SEND_ERR,
    WAIT_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_FALL,
    SND_RISE
  } snd_state_t;

endpackage

// File: rtl/uart_byte_sender.sv
// Launches one byte into the UART TX once tx_ready is high, then waits for the
// transmitter to go busy and idle again before reporting the byte as sent.
module uart_byte_sender
  import uart_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              tx_ready_i,
  output logic              launch_o,
  output logic              sent_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_start_o
);

  snd_state_t        state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              start_q, start_d;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    start_d  = 1'b0;
    launch_o = 1'b0;
    sent_o   = 1'b0;
    case (state_q)
      SND_IDLE: begin
        if (req_i && tx_ready_i) begin
          launch_o = 1'b1;
          start_d  = 1'b1;
          data_d   = byte_i;
          state_d  = SND_FALL;
        end
      end
      SND_FALL: begin
        if (!tx_ready_i) state_d = SND_RISE;
      end
      SND_RISE: begin
        if (tx_ready_i) begin
          sent_o  = 1'b1;
          state_d = SND_IDLE;
        end
      end
      default: state_d = SND_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SND_IDLE;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  assign tx_data_o  = data_q;
  assign tx_start_o = start_q;

endmodule

// File: rtl/uart_mult_sequencer.sv
// Parses {opcode, A, B} frames from the UART RX stream, runs one multiply and
// returns the product MSB first; reports bad opcodes, inter-byte timeouts, overruns.
module uart_mult_sequencer
  import uart_seq_pkg::*;
#(
  parameter int                DATA_W         = DEF_DATA_W,
  parameter int                TIMEOUT_CYCLES = 1000000,
  parameter logic [BYTE_W-1:0] OPC_MUL        = DEF_OPC_MUL,
  parameter logic [BYTE_W-1:0] ERR_BYTE       = DEF_ERR_BYTE
) (
  input  logic                clk_int,
  input  logic                uart_reset,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic                tx_ready,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_start,
  output logic [DATA_W-1:0]   mult_a,
  output logic [DATA_W-1:0]   mult_b,
  output logic                mult_start,
  input  logic                mult_done,
  input  logic [2*DATA_W-1:0] mult_product,
  output logic                busy,
  output logic                timeout_err,
  output logic                overrun
);

  localparam int PW    = 2 * DATA_W;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              mstart_q, mstart_d;
  logic              to_q, to_d;
  logic              ovr_q, ovr_d;

  logic              snd_req;
  logic [BYTE_W-1:0] snd_byte;
  logic              snd_launch;
  logic              snd_sent;

  // The HI byte is offered straight off mult_done so it can launch the next cycle.
  always_comb begin
    snd_req  = 1'b0;
    snd_byte = ERR_BYTE;
    case (state_q)
      MUL: begin
        snd_req  = mult_done;
        snd_byte = mult_product[PW-1 -: BYTE_W];
      end
      SEND_HI: begin
        snd_req  = 1'b1;
        snd_byte = prod_q[PW-1 -: BYTE_W];
      end
      SEND_LO: begin
        snd_req  = 1'b1;
        snd_byte = prod_q[BYTE_W-1:0];
      end
      SEND_ERR: snd_req = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    gap_d    = '0;
    mstart_d = 1'b0;
    to_d     = 1'b0;
    ovr_d    = ovr_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) state_d = (rx_data == OPC_MUL) ? GET_A : SEND_ERR;
      end
      GET_A, GET_B: begin
        // Expiry wins over a coincident byte, which is silently dropped.
        if (gap_q == GAP_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (rx_valid) begin
          if (state_q == GET_A) begin
            a_d     = DATA_W'(rx_data);
            state_d = GET_B;
          end else begin
            b_d      = DATA_W'(rx_data);
            mstart_d = 1'b1;
            state_d  = MUL;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      MUL: begin
        if (mult_done) begin
          prod_d  = mult_product;
          state_d = snd_launch ? WAIT_HI : SEND_HI;
        end
      end
      SEND_HI:  if (snd_launch) state_d = WAIT_HI;
      WAIT_HI:  if (snd_sent)   state_d = SEND_LO;
      SEND_LO:  if (snd_launch) state_d = WAIT_LO;
      WAIT_LO:  if (snd_sent)   state_d = IDLE;
      SEND_ERR: if (snd_launch) state_d = WAIT_ERR;
      WAIT_ERR: if (snd_sent)   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (rx_valid && !(state_q inside {IDLE, GET_A, GET_B})) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      gap_q    <= '0;
      mstart_q <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      gap_q    <= gap_d;
      mstart_q <= mstart_d;
      to_q     <= to_d;
      ovr_q    <= ovr_d;
    end
  end

  uart_byte_sender u_sender (
    .clk_i      (clk_int),
    .rst_i      (uart_reset),
    .req_i      (snd_req),
    .byte_i     (snd_byte),
    .tx_ready_i (tx_ready),
    .launch_o   (snd_launch),
    .sent_o     (snd_sent),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start)
  );

  assign mult_a      = a_q;
  assign mult_b      = b_q;
  assign mult_start  = mstart_q;
  assign timeout_err = to_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule
